// File: rtl/mask_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mask_row_buffer
//  Description : Circular bit buffer for image mask rows. Holds up to
//                N_ROWS*IMG_WIDTH mask bits. It reports per-row completion,
//                fill state and a sticky overflow flag, and returns one bit
//                per consumer request with a single cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_row_buffer #(
    parameter int IMG_WIDTH = 640,
    parameter int N_ROWS    = 12
) (
    input  logic                                   i_CLK,
    input  logic                                   i_RSTn,
    input  logic                                   i_MASK,
    input  logic                                   i_MASK_VALID,
    input  logic                                   i_RD_REQ,
    output logic                                   o_MASK,
    output logic                                   o_MASK_VALID,
    output logic                                   o_FULL12_ROW,
    output logic                                   o_ROW_AVAIL,
    output logic                                   o_EMPTY,
    output logic [$clog2(IMG_WIDTH*N_ROWS+1)-1:0]  o_COUNT,
    output logic                                   o_ROW_DONE,
    output logic                                   o_OVERFLOW
);

    localparam int C_D    = IMG_WIDTH * N_ROWS;
    localparam int C_AW   = (C_D > 1) ? $clog2(C_D) : 1;
    localparam int C_CW   = $clog2(C_D + 1);
    localparam int C_COLW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [C_AW-1:0]   C_LAST_ADDR = C_AW'(C_D - 1);
    localparam logic [C_AW-1:0]   C_ADDR_ONE  = C_AW'(1);
    localparam logic [C_COLW-1:0] C_LAST_COL  = C_COLW'(IMG_WIDTH - 1);
    localparam logic [C_COLW-1:0] C_COL_ONE   = C_COLW'(1);
    localparam logic [C_CW-1:0]   C_FULL_CNT  = C_CW'(C_D);
    localparam logic [C_CW-1:0]   C_ROW_CNT   = C_CW'(IMG_WIDTH);
    localparam logic [C_CW-1:0]   C_CNT_ONE   = C_CW'(1);

    logic              r_run;
    logic [C_AW-1:0]   r_wp;
    logic [C_AW-1:0]   r_rp;
    logic [C_COLW-1:0] r_col;
    logic [C_CW-1:0]   r_count;
    logic              r_mask;
    logic              r_mask_valid;
    logic              r_row_done;
    logic              r_overflow;
    logic              r_mem [C_D];

    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_drop;

    // Acceptance is decided from the registered count at the start of the cycle;
    // a read at count 0 is refused even if a write lands in the same cycle.
    assign w_full    = (r_count == C_FULL_CNT);
    assign w_wr_acc  = r_run && i_MASK_VALID && !w_full;
    assign w_wr_drop = r_run && i_MASK_VALID && w_full;
    assign w_rd_acc  = r_run && i_RD_REQ && (r_count != '0);

    // Holds off all accepts on the first edge after reset release.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) r_run <= 1'b0;
        else         r_run <= 1'b1;
    end

    // Bit array storage, deliberately not reset; stale data is unreachable at count 0.
    always_ff @(posedge i_CLK) begin
        if (w_wr_acc) r_mem[r_wp] <= i_MASK;
    end

    // Pointers, column tracker, occupancy count and status flags.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_col        <= '0;
            r_count      <= '0;
            r_mask       <= 1'b0;
            r_mask_valid <= 1'b0;
            r_row_done   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_mask_valid <= w_rd_acc;
            r_row_done   <= w_wr_acc && (r_col == C_LAST_COL);
            if (w_wr_drop) r_overflow <= 1'b1;
            if (w_wr_acc) begin
                r_wp  <= (r_wp == C_LAST_ADDR) ? '0 : r_wp + C_ADDR_ONE;
                r_col <= (r_col == C_LAST_COL) ? '0 : r_col + C_COL_ONE;
            end
            if (w_rd_acc) begin
                // Old content is read even if the same address is written now.
                r_mask <= r_mem[r_rp];
                r_rp   <= (r_rp == C_LAST_ADDR) ? '0 : r_rp + C_ADDR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_MASK       = r_mask;
    assign o_MASK_VALID = r_mask_valid;
    assign o_COUNT      = r_count;
    assign o_ROW_DONE   = r_row_done;
    assign o_OVERFLOW   = r_overflow;
    assign o_FULL12_ROW = w_full;
    assign o_ROW_AVAIL  = (r_count >= C_ROW_CNT);
    assign o_EMPTY      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_mask_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_row_buffer
//  Description : Directed self-checking bench for mask_row_buffer with
//                IMG_WIDTH=4, N_ROWS=3 (12-bit buffer).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_row_buffer;

    localparam int C_W = 4;
    localparam int C_R = 3;

    logic       clk;
    logic       rst_n;
    logic       mask_in;
    logic       mask_in_valid;
    logic       rd_req;
    logic       mask_out;
    logic       mask_out_valid;
    logic       full;
    logic       row_avail;
    logic       empty;
    logic [3:0] count;
    logic       row_done;
    logic       overflow;

    logic [6:0] status;
    logic [3:0] flags;
    int         checks;
    int         errors;

    assign status = {count, empty, row_avail, full};
    assign flags  = {mask_out_valid, mask_out, row_done, overflow};

    mask_row_buffer #(.IMG_WIDTH(C_W), .N_ROWS(C_R)) dut (
        .i_CLK        (clk),
        .i_RSTn       (rst_n),
        .i_MASK       (mask_in),
        .i_MASK_VALID (mask_in_valid),
        .i_RD_REQ     (rd_req),
        .o_MASK       (mask_out),
        .o_MASK_VALID (mask_out_valid),
        .o_FULL12_ROW (full),
        .o_ROW_AVAIL  (row_avail),
        .o_EMPTY      (empty),
        .o_COUNT      (count),
        .o_ROW_DONE   (row_done),
        .o_OVERFLOW   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset and step past the edge on which nothing may be accepted.
    task automatic do_reset();
        mask_in_valid = 1'b0;
        rd_req        = 1'b0;
        rst_n         = 1'b0;
        #2;
        rst_n         = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (status !== 7'b0000_100) begin
            errors++;
            $display("FAIL reset_status got %b exp %b", status, 7'b0000_100);
        end
        checks++;
        if (flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp %b", flags, 4'b0000);
        end
    endtask

    // First edge after release ignored; read at count 0 ignored beside a write.
    task automatic test_reset_sync();
        rst_n = 1'b1;
        mask_in = 1'b1; mask_in_valid = 1'b1; rd_req = 1'b1;
        tick();
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL release_edge_count got %0d exp 0", count);
        end
        tick();
        checks++;
        if ({count, mask_out_valid} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL empty_rw got count %0d valid %b exp 1 0", count, mask_out_valid);
        end
        mask_in_valid = 1'b0;
        tick();
        rd_req = 1'b0;
        checks++;
        if ({count, mask_out_valid, mask_out} !== {4'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL empty_rw_read got count %0d valid %b mask %b exp 0 1 1",
                     count, mask_out_valid, mask_out);
        end
    endtask

    task automatic test_row();
        logic [0:3] bits;
        bits = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mask_in = bits[i]; mask_in_valid = 1'b1;
            tick();
            checks++;
            if (row_done !== (i == 3)) begin
                errors++;
                $display("FAIL row_done_%0d got %b exp %b", i, row_done, (i == 3));
            end
        end
        mask_in_valid = 1'b0;
        tick();
        checks++;
        if ({status, row_done} !== {7'b0100_010, 1'b0}) begin
            errors++;
            $display("FAIL row_status got %b exp %b", {status, row_done}, {7'b0100_010, 1'b0});
        end
    endtask

    task automatic test_full_overflow();
        logic [0:7] bits;
        bits = 8'b0110_1100;
        for (int i = 0; i < 8; i++) begin
            mask_in = bits[i]; mask_in_valid = 1'b1;
            tick();
            checks++;
            if (row_done !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL fill_row_done_%0d got %b exp %b", i, row_done, (i == 3 || i == 7));
            end
        end
        mask_in_valid = 1'b0;
        checks++;
        if ({status, overflow} !== {7'b1100_011, 1'b0}) begin
            errors++;
            $display("FAIL full_status got %b exp %b", {status, overflow}, {7'b1100_011, 1'b0});
        end
        mask_in = 1'b1; mask_in_valid = 1'b1;
        tick();
        mask_in_valid = 1'b0;
        checks++;
        if ({status, overflow, row_done} !== {7'b1100_011, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL overflow got %b exp %b", {status, overflow, row_done},
                     {7'b1100_011, 1'b1, 1'b0});
        end
    endtask

    // Drain in write order, refuse at empty, then confirm the column did not move.
    task automatic test_read_all();
        logic [0:11] exp_bits;
        logic [0:3]  row;
        exp_bits = 12'b1011_0110_1100;
        row      = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            rd_req = 1'b1;
            tick();
            checks++;
            if ({mask_out_valid, mask_out} !== {1'b1, exp_bits[i]}) begin
                errors++;
                $display("FAIL read_%0d got valid %b mask %b exp 1 %b",
                         i, mask_out_valid, mask_out, exp_bits[i]);
            end
        end
        checks++;
        if (status !== 7'b0000_100) begin
            errors++;
            $display("FAIL drained_status got %b exp %b", status, 7'b0000_100);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL read_empty got %b exp %b", flags, 4'b0001);
        end
        for (int i = 0; i < 4; i++) begin
            mask_in = row[i]; mask_in_valid = 1'b1;
            tick();
            checks++;
            if (row_done !== (i == 3)) begin
                errors++;
                $display("FAIL col_kept_%0d got %b exp %b", i, row_done, (i == 3));
            end
        end
        mask_in_valid = 1'b0;
    endtask

    // Count at 5 with read and write together; drain to confirm both pointers moved.
    task automatic test_simultaneous();
        logic [0:4] rest;
        rest = 5'b10110;
        mask_in = 1'b1; mask_in_valid = 1'b1;
        tick();
        mask_in = 1'b0; rd_req = 1'b1;
        tick();
        mask_in_valid = 1'b0;
        checks++;
        if ({status, mask_out_valid, mask_out} !== {7'b0101_010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL simul got %b exp %b", {status, mask_out_valid, mask_out},
                     {7'b0101_010, 1'b1, 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({mask_out_valid, mask_out} !== {1'b1, rest[i]}) begin
                errors++;
                $display("FAIL simul_drain_%0d got valid %b mask %b exp 1 %b",
                         i, mask_out_valid, mask_out, rest[i]);
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (status !== 7'b0000_100) begin
            errors++;
            $display("FAIL simul_empty got %b exp %b", status, 7'b0000_100);
        end
    endtask

    // 30 writes, 25 of them paired with reads: pointers wrap twice.
    task automatic test_wrap();
        logic [29:0] pat;
        pat = 30'h2D3C_9A57;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mask_in = pat[i]; mask_in_valid = 1'b1;
            tick();
        end
        rd_req = 1'b1;
        for (int k = 0; k < 25; k++) begin
            mask_in = pat[5 + k];
            tick();
            checks++;
            if ({mask_out_valid, mask_out} !== {1'b1, pat[k]}) begin
                errors++;
                $display("FAIL wrap_read_%0d got valid %b mask %b exp 1 %b",
                         k, mask_out_valid, mask_out, pat[k]);
            end
        end
        rd_req = 1'b0; mask_in_valid = 1'b0;
        checks++;
        if ({status, overflow} !== {7'b0101_010, 1'b0}) begin
            errors++;
            $display("FAIL wrap_status got %b exp %b", {status, overflow}, {7'b0101_010, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        logic [0:5] six;
        logic [0:3] row;
        six = 6'b110100;
        row = 4'b0111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mask_in = six[i]; mask_in_valid = 1'b1;
            tick();
        end
        mask_in_valid = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        checks++;
        if ({mask_out_valid, mask_out, count} !== {1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL pre_reset got %b exp %b", {mask_out_valid, mask_out, count},
                     {1'b1, 1'b1, 4'd5});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({status, flags} !== {7'b0000_100, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", {status, flags}, {7'b0000_100, 4'b0000});
        end
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            mask_in = row[i]; mask_in_valid = 1'b1;
            tick();
            checks++;
            if (row_done !== (i == 3)) begin
                errors++;
                $display("FAIL post_reset_row_%0d got %b exp %b", i, row_done, (i == 3));
            end
        end
        mask_in_valid = 1'b0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        checks++;
        if ({status, mask_out_valid, mask_out} !== {7'b0011_000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset_read got %b exp %b", {status, mask_out_valid, mask_out},
                     {7'b0011_000, 1'b1, 1'b0});
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        mask_in       = 1'b0;
        mask_in_valid = 1'b0;
        rd_req        = 1'b0;
        test_reset();
        test_reset_sync();
        test_row();
        test_full_overflow();
        test_read_all();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mask_row_buffer.md
MASK_ROW_BUFFER -- requirements
Module: mask_row_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning mask bits per image row.
REQ-002 SHALL have parameter N_ROWS, default 12, meaning rows of capacity; depth D = N_ROWS*IMG_WIDTH bits.
REQ-003 SHALL have port i_CLK  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port i_RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_MASK  input  1  mask bit from the mask multiplexer stage.
REQ-006 SHALL have port i_MASK_VALID  input  1  i_MASK qualifier, one bit per cycle.
REQ-007 SHALL have port i_RD_REQ  input  1  consumer request for one mask bit.
REQ-008 SHALL have port o_MASK  output  1  read mask bit.
REQ-009 SHALL have port o_MASK_VALID  output  1  o_MASK qualifier.
REQ-010 SHALL have port o_FULL12_ROW  output  1  high when stored bit count equals D.
REQ-011 SHALL have port o_ROW_AVAIL  output  1  high when stored bit count >= IMG_WIDTH.
REQ-012 SHALL have port o_EMPTY  output  1  high when stored bit count is 0.
REQ-013 SHALL have port o_COUNT  output  $clog2(D+1)  stored bit count.
REQ-014 SHALL have port o_ROW_DONE  output  1  one-cycle pulse when a write completes a row.
REQ-015 SHALL have port o_OVERFLOW  output  1  sticky flag, a valid bit was dropped.

Function
REQ-016 SHALL store bits in a circular D-entry bit array addressed by write pointer WP and read pointer RP, each 0..D-1, wrapping D-1 -> 0.
REQ-017 SHALL accept a write when i_MASK_VALID=1 and o_COUNT<D at the cycle start: store at WP, WP increments.
REQ-018 SHALL drop a write when i_MASK_VALID=1 and o_COUNT=D, even if a read is accepted that cycle, and set o_OVERFLOW=1 on the next edge.
REQ-019 SHALL accept a read when i_RD_REQ=1 and o_COUNT>0 at the cycle start: RP increments; a request at o_COUNT=0 is ignored, with no pointer change and no valid.
REQ-020 SHALL present the bit at RP on o_MASK with o_MASK_VALID=1 exactly one cycle after an accepted read; otherwise o_MASK_VALID=0 and o_MASK holds its last value.
REQ-021 SHALL update o_COUNT by +1 (write only), -1 (read only), 0 (both accepted or neither), registered.
REQ-022 SHALL drive o_FULL12_ROW, o_ROW_AVAIL and o_EMPTY combinationally from registered o_COUNT.
REQ-023 SHALL keep a column counter 0..IMG_WIDTH-1 on accepted writes only, wrap it to 0 after IMG_WIDTH-1, and pulse o_ROW_DONE one cycle after the accepted write at column IMG_WIDTH-1.
REQ-024 SHALL not advance the column counter on dropped writes.
REQ-025 SHALL allow a simultaneous read and write at o_COUNT=0 to accept only the write; the read is ignored.
REQ-026 SHALL return, on a read of the address written in the same cycle, the previously stored content. This is unreachable under REQ-019 and REQ-025 and is stated for completeness.
REQ-027 SHALL clear o_OVERFLOW only by reset.

Reset
REQ-028 SHALL, while i_RSTn=0 and independent of i_CLK: set WP=0, RP=0, column=0, o_COUNT=0, o_MASK=0, o_MASK_VALID=0, o_ROW_DONE=0, o_OVERFLOW=0, giving o_EMPTY=1, o_FULL12_ROW=0, o_ROW_AVAIL=0.
REQ-029 SHALL not clear bit-array contents on reset; contents are unreadable until rewritten because o_COUNT=0.
REQ-030 SHALL, on reset asserted mid-row or mid-read, abandon the partial row and any pending o_MASK_VALID; after release the first accepted write lands at address 0, column 0.
REQ-031 SHALL synchronise reset release so that no write or read is accepted on the first edge after release.

Verification (IMG_WIDTH=4, N_ROWS=3, D=12)
REQ-032 SHALL cover: write 1,0,1,1 -> o_ROW_DONE pulses one cycle after the 4th bit; o_COUNT=4; o_ROW_AVAIL=1; o_EMPTY=0.
REQ-033 SHALL cover: 12 writes then a 13th -> o_FULL12_ROW=1 after the 12th; 13th dropped; o_OVERFLOW=1; o_COUNT stays 12; column counter unchanged.
REQ-034 SHALL cover: full buffer, 12 reads -> bits return in write order, each one cycle after its request; o_EMPTY=1 after the last read; a 13th request gives no o_MASK_VALID.
REQ-035 SHALL cover: o_COUNT=5 with read and write in the same cycle -> o_COUNT stays 5; WP and RP each advance by 1.
REQ-036 SHALL cover: 30 writes interleaved with 25 reads -> pointers wrap past 11; read data matches the write order; o_COUNT=5.
REQ-037 SHALL cover: i_RSTn pulsed low asynchronously after 6 writes -> outputs go to their reset values immediately; a subsequent 4-bit row completes with o_ROW_DONE.
